// File: rtl/ct_idu_rf_prf_pkg.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_prf_pkg
// Shared sizing and types for the integer physical register file read port.
//   PREG_NUM    : number of physical registers
//   PREG_IDX_W  : width of a physical register index
//   DATA_W      : width of one register value
//   WB_PORTS    : writeback ports (0 iu pipe0, 1 iu pipe1, 2 lsu pipe3,
//                 3 mat_cfg pipe8)
// ---------------------------------------------------------------------------
package ct_idu_rf_prf_pkg;

    localparam int PREG_NUM   = 96;
    localparam int PREG_IDX_W = 7;
    localparam int DATA_W     = 64;
    localparam int WB_PORTS   = 4;

    typedef logic [PREG_IDX_W-1:0] preg_idx_t;
    typedef logic [DATA_W-1:0]     preg_data_t;

    // True when the index names a physical register that exists.
    function automatic logic preg_in_range(input preg_idx_t idx);
        return (idx < PREG_IDX_W'(PREG_NUM));
    endfunction

endpackage

// File: rtl/ct_idu_rf_prf_rd_port_chk.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_prf_rd_port_chk
// Simulation checks for the PRF read port.
//   clk, rst      : port clock and asynchronous active-high reset
//   wb_vld/preg   : writeback bus, two valid ports must never share a preg
//   accept        : a request is being loaded this cycle
//   req_preg      : requested index, must name an existing register
// ---------------------------------------------------------------------------
module ct_idu_rf_prf_rd_port_chk
    import ct_idu_rf_prf_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WB_PORTS-1:0]            wb_vld,
    input  logic [WB_PORTS*PREG_IDX_W-1:0] wb_preg,
    input  logic                           accept,
    input  logic [PREG_IDX_W-1:0]          req_preg
);

    logic dup_s;

    // Any two valid writeback ports targeting the same preg.
    always_comb begin
        dup_s = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            for (int q = p + 1; q < WB_PORTS; q++) begin
                if (wb_vld[p] && wb_vld[q] &&
                    (wb_preg[p*PREG_IDX_W +: PREG_IDX_W] == wb_preg[q*PREG_IDX_W +: PREG_IDX_W])) begin
                    dup_s = 1'b1;
                end else begin
                    dup_s = dup_s;
                end
            end
        end
    end

    a_wb_single_writer: assert property (@(posedge clk) disable iff (rst) !dup_s);

    a_req_preg_range: assert property (@(posedge clk) disable iff (rst)
        accept |-> preg_in_range(req_preg));

endmodule

// File: rtl/ct_idu_rf_prf_wb_bypass.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_prf_wb_bypass
// Combinational writeback match for one preg index.
//   preg_i      : index to compare against the writeback bus
//   wb_vld_i    : per-port writeback valid
//   wb_preg_i   : per-port destination preg (flattened)
//   wb_data_i   : per-port writeback data (flattened)
//   hit_o       : some valid writeback targets preg_i
//   hit_data_o  : data of the matching port; lowest port index wins
// ---------------------------------------------------------------------------
module ct_idu_rf_prf_wb_bypass
    import ct_idu_rf_prf_pkg::*;
(
    input  logic [PREG_IDX_W-1:0]          preg_i,
    input  logic [WB_PORTS-1:0]            wb_vld_i,
    input  logic [WB_PORTS*PREG_IDX_W-1:0] wb_preg_i,
    input  logic [WB_PORTS*DATA_W-1:0]     wb_data_i,
    output logic                           hit_o,
    output logic [DATA_W-1:0]              hit_data_o
);

    logic       hit_s;
    preg_data_t data_s;

    // Priority match: scan from the highest port down so the lowest index
    // is written last and therefore wins when several ports collide.
    always_comb begin
        hit_s  = 1'b0;
        data_s = {DATA_W{1'b0}};
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_vld_i[p] && (wb_preg_i[p*PREG_IDX_W +: PREG_IDX_W] == preg_i)) begin
                hit_s  = 1'b1;
                data_s = wb_data_i[p*DATA_W +: DATA_W];
            end else begin
                data_s = data_s;
            end
        end
    end

    assign hit_o      = hit_s;
    assign hit_data_o = data_s;

endmodule

// File: rtl/gated_clk_cell.sv
// ---------------------------------------------------------------------------
// gated_clk_cell
// Glitch-free clock gate: the enable is captured by a latch that is
// transparent while the clock is low, then ANDed with the clock.
//   clk_in             : free-running clock
//   global_en          : chip-level enable
//   module_en          : force-on for the whole module
//   local_en           : per-register-group functional enable
//   external_en        : force-on from outside the module
//   pad_yy_icg_scan_en : scan mode, clock always runs
//   clk_out            : gated clock
// ---------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_s;
    logic clk_en_lat_q;

    assign clk_en_s = (global_en & (module_en | local_en | external_en)) | pad_yy_icg_scan_en;

    // Enable latch, open during the low phase so clk_out cannot glitch.
    always_latch begin
        if (!clk_in) begin
            clk_en_lat_q = clk_en_s;
        end
    end

    assign clk_out = clk_in & clk_en_lat_q;

endmodule

// File: rtl/ct_idu_rf_prf_rd_port.sv
// ---------------------------------------------------------------------------
// ct_idu_rf_prf_rd_port
// Single-entry registered read port onto the integer PRF. A request accepted
// in cycle N returns its value in N+1; writebacks in N are bypassed, and a
// stalled response is refreshed by any later writeback to the same preg.
//   forever_cpuclk  : clock
//   cpurst          : asynchronous active-high reset
//   rtu_yy_xx_flush : drop the held response and any request this cycle
//   x_preg_dout     : flattened PRF contents, entry i at [i*DATA_W +: DATA_W]
//   x_wb_vld/preg/data : writeback bus
//   rd_req_vld/preg/rdy: request handshake
//   rd_rsp_vld/preg/data/rdy: response handshake
// ---------------------------------------------------------------------------
module ct_idu_rf_prf_rd_port
    import ct_idu_rf_prf_pkg::*;
(
    input  logic                           forever_cpuclk,
    input  logic                           cpurst,
    input  logic                           rtu_yy_xx_flush,
    input  logic [PREG_NUM*DATA_W-1:0]     x_preg_dout,
    input  logic [WB_PORTS-1:0]            x_wb_vld,
    input  logic [WB_PORTS*PREG_IDX_W-1:0] x_wb_preg,
    input  logic [WB_PORTS*DATA_W-1:0]     x_wb_data,
    input  logic                           rd_req_vld,
    input  logic [PREG_IDX_W-1:0]          rd_req_preg,
    output logic                           rd_req_rdy,
    output logic                           rd_rsp_vld,
    output logic [PREG_IDX_W-1:0]          rd_rsp_preg,
    output logic [DATA_W-1:0]              rd_rsp_data,
    input  logic                           rd_rsp_rdy
);

    preg_data_t prf_s [PREG_NUM];
    preg_data_t arr_data_s;
    logic       req_hit_s;
    preg_data_t req_hit_data_s;
    logic       held_hit_s;
    preg_data_t held_hit_data_s;
    logic       accept_s;
    logic       hold_s;
    logic       local_en_s;
    logic       data_clk_s;

    logic       rsp_vld_q;
    logic       rsp_vld_d;
    preg_idx_t  rsp_preg_q;
    preg_idx_t  rsp_preg_d;
    preg_data_t rsp_data_q;
    preg_data_t rsp_data_d;

    for (genvar i = 0; i < PREG_NUM; i++) begin : g_prf
        assign prf_s[i] = x_preg_dout[i*DATA_W +: DATA_W];
    end

    // Array lookup; an out-of-range index has no defined value.
    always_comb begin
        if (preg_in_range(rd_req_preg)) begin
            arr_data_s = prf_s[rd_req_preg];
        end else begin
            arr_data_s = {DATA_W{1'bx}};
        end
    end

    ct_idu_rf_prf_wb_bypass u_req_bypass (
        .preg_i     (rd_req_preg),
        .wb_vld_i   (x_wb_vld),
        .wb_preg_i  (x_wb_preg),
        .wb_data_i  (x_wb_data),
        .hit_o      (req_hit_s),
        .hit_data_o (req_hit_data_s)
    );

    ct_idu_rf_prf_wb_bypass u_held_bypass (
        .preg_i     (rsp_preg_q),
        .wb_vld_i   (x_wb_vld),
        .wb_preg_i  (x_wb_preg),
        .wb_data_i  (x_wb_data),
        .hit_o      (held_hit_s),
        .hit_data_o (held_hit_data_s)
    );

    assign rd_req_rdy = ~rsp_vld_q | rd_rsp_rdy;
    assign accept_s   = rd_req_vld & rd_req_rdy & ~rtu_yy_xx_flush;
    assign hold_s     = rsp_vld_q & ~rd_rsp_rdy;
    assign local_en_s = accept_s | (hold_s & held_hit_s);

    // Valid next state: flush wins, then a new load, then consumption.
    always_comb begin
        rsp_vld_d = rsp_vld_q;
        if (rtu_yy_xx_flush) begin
            rsp_vld_d = 1'b0;
        end else if (accept_s) begin
            rsp_vld_d = 1'b1;
        end else if (rd_rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end else begin
            rsp_vld_d = rsp_vld_q;
        end
    end

    // Datapath next state: only meaningful when the gated clock fires.
    always_comb begin
        rsp_preg_d = rsp_preg_q;
        rsp_data_d = rsp_data_q;
        if (accept_s) begin
            rsp_preg_d = rd_req_preg;
            rsp_data_d = req_hit_s ? req_hit_data_s : arr_data_s;
        end else begin
            rsp_preg_d = rsp_preg_q;
            rsp_data_d = held_hit_data_s;
        end
    end

    gated_clk_cell u_data_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (1'b0),
        .local_en           (local_en_s),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (1'b0),
        .clk_out            (data_clk_s)
    );

    // Response valid flag on the free-running clock.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // Response preg/data on the gated clock.
    always_ff @(posedge data_clk_s or posedge cpurst) begin
        if (cpurst) begin
            rsp_preg_q <= {PREG_IDX_W{1'b0}};
            rsp_data_q <= {DATA_W{1'b0}};
        end else begin
            rsp_preg_q <= rsp_preg_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rd_rsp_vld  = rsp_vld_q;
    assign rd_rsp_preg = rsp_preg_q;
    assign rd_rsp_data = rsp_data_q;

    ct_idu_rf_prf_rd_port_chk u_chk (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .wb_vld   (x_wb_vld),
        .wb_preg  (x_wb_preg),
        .accept   (accept_s),
        .req_preg (rd_req_preg)
    );

endmodule
